// File: rtl/lcd_ddram_reader.sv
// lcd_ddram_reader
// Reads the 32 visible characters of a 16x2 HD44780-compatible LCD back out of
// DDRAM and writes them into a 32-entry character RAM (0-15 line 1, 16-31
// line 2). The LCD pins are borrowed from the main controller through a
// bus_req/bus_gnt handshake; the top level muxes pins and owns the tristate.
//
// Build option: define LCD_READER_BUSY_POLL_EN to replace the fixed wait after
// each set-address command with busy-flag polling, bounded to CMD_WAIT/55 polls.
//
// All outputs are registered from the next-state values so the LCD strobes are
// glitch-free and line up exactly with the state/counter they belong to.
module lcd_ddram_reader #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 25,
  parameter int CMD_WAIT  = 2500
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_in,
  output logic [4:0] waddr,
  output logic [7:0] dout,
  output logic       we
);

  // One bus cycle is setup + enable + hold; a single counter times both the
  // bus cycles and the post-command wait, so it is sized for the longer one.
  localparam int CYC_LEN = SETUP_CYC + EN_CYC + HOLD_CYC;
  localparam int CNT_MAX = (CMD_WAIT > CYC_LEN) ? CMD_WAIT : CYC_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] EN_ON     = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_OFF    = CNT_W'(SETUP_CYC + EN_CYC);
  localparam logic [CNT_W-1:0] CAP_AT    = CNT_W'(SETUP_CYC + EN_CYC - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYC_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CMD_WAIT - 1);

`ifdef LCD_READER_BUSY_POLL_EN
  // Poll budget roughly matches the fixed wait it replaces.
  localparam int POLL_MAX = ((CMD_WAIT / 55) > 0) ? (CMD_WAIT / 55) : 1;
  localparam int POLL_W   = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SETADDR = 3'd2,
    S_WAITCMD = 3'd3,
    S_READ    = 3'd4,
    S_WRRAM   = 3'd5,
    S_DONE    = 3'd6,
    S_POLL    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             line_q, line_d;
  logic [3:0]       col_q, col_d;
  logic [7:0]       data_q, data_d;
`ifdef LCD_READER_BUSY_POLL_EN
  logic [POLL_W-1:0] poll_q, poll_d;
`endif

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bus_req_q, bus_req_d;
  logic       rs_q, rs_d;
  logic       rw_q, rw_d;
  logic       en_q, en_d;
  logic [7:0] lcd_dat_q, lcd_dat_d;
  logic       oe_q, oe_d;
  logic [4:0] waddr_q, waddr_d;
  logic [7:0] dout_q, dout_d;
  logic       we_q, we_d;
  logic       en_win;

  // State, counters and captured byte; reset clears the sequence immediately.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= 1'b0;
      col_q   <= 4'd0;
      data_q  <= 8'h00;
`ifdef LCD_READER_BUSY_POLL_EN
      poll_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      col_q   <= col_d;
      data_q  <= data_d;
`ifdef LCD_READER_BUSY_POLL_EN
      poll_q  <= poll_d;
`endif
    end
  end

  // Next-state, cycle timing, line/column stepping and LCD byte capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    col_d   = col_q;
    data_d  = data_q;
`ifdef LCD_READER_BUSY_POLL_EN
    poll_d  = poll_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          cnt_d   = '0;
          line_d  = 1'b0;
          col_d   = 4'd0;
        end
      end
      // Grant is only looked at here; once owned, the pins are kept until DONE.
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_SETADDR;
          cnt_d   = '0;
        end
      end
      S_SETADDR: begin
        if (cnt_q == CYC_LAST) begin
          cnt_d   = '0;
`ifdef LCD_READER_BUSY_POLL_EN
          state_d = S_POLL;
          poll_d  = '0;
`else
          state_d = S_WAITCMD;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAITCMD: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Data is taken on the last cycle the enable is high.
      S_READ: begin
        if (cnt_q == CAP_AT) data_d = lcd_data_in;
        if (cnt_q == CYC_LAST) begin
          state_d = S_WRRAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef LCD_READER_BUSY_POLL_EN
      // Busy-flag read; repeat while BF is set and budget remains.
      S_POLL: begin
        if (cnt_q == CAP_AT) data_d = lcd_data_in;
        if (cnt_q == CYC_LAST) begin
          cnt_d  = '0;
          poll_d = poll_q + 1'b1;
          if (data_d[7] && (poll_q < POLL_LAST)) state_d = S_POLL;
          else                                   state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      // The LCD auto-increments its address, so only a line change needs a new command.
      S_WRRAM: begin
        cnt_d = '0;
        if (col_q != 4'd15) begin
          col_d   = col_q + 4'd1;
          state_d = S_READ;
        end else if (!line_q) begin
          line_d  = 1'b1;
          col_d   = 4'd0;
          state_d = S_SETADDR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so outputs switch with the state itself.
  // oe is only ever raised together with rw=0, which keeps the two exclusive.
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bus_req_d = 1'b0;
    rs_d      = 1'b0;
    rw_d      = 1'b1;
    en_d      = 1'b0;
    lcd_dat_d = 8'h00;
    oe_d      = 1'b0;
    waddr_d   = 5'd0;
    dout_d    = 8'h00;
    we_d      = 1'b0;
    en_win    = (cnt_d >= EN_ON) && (cnt_d < EN_OFF);
    case (state_d)
      S_REQ, S_WAITCMD: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
      end
      S_SETADDR: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
        rw_d      = 1'b0;
        oe_d      = 1'b1;
        lcd_dat_d = line_d ? 8'hC0 : 8'h80;
        en_d      = en_win;
      end
      S_READ: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
        rs_d      = 1'b1;
        en_d      = en_win;
      end
      S_POLL: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
        en_d      = en_win;
      end
      S_WRRAM: begin
        busy_d    = 1'b1;
        bus_req_d = 1'b1;
        rs_d      = 1'b1;
        we_d      = 1'b1;
        waddr_d   = {line_d, col_d};
        dout_d    = data_d;
      end
      // Pins are released and busy drops together with the done pulse.
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops en/oe asynchronously and parks rw high.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bus_req_q <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b1;
      en_q      <= 1'b0;
      lcd_dat_q <= 8'h00;
      oe_q      <= 1'b0;
      waddr_q   <= 5'd0;
      dout_q    <= 8'h00;
      we_q      <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      bus_req_q <= bus_req_d;
      rs_q      <= rs_d;
      rw_q      <= rw_d;
      en_q      <= en_d;
      lcd_dat_q <= lcd_dat_d;
      oe_q      <= oe_d;
      waddr_q   <= waddr_d;
      dout_q    <= dout_d;
      we_q      <= we_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus_req      = bus_req_q;
  assign lcd_rs       = rs_q;
  assign lcd_rw       = rw_q;
  assign lcd_en       = en_q;
  assign lcd_data_out = lcd_dat_q;
  assign lcd_data_oe  = oe_q;
  assign waddr        = waddr_q;
  assign dout         = dout_q;
  assign we           = we_q;

endmodule

// File: tb/tb_lcd_ddram_reader.sv
// tb_lcd_ddram_reader
// Directed bench for lcd_ddram_reader with a small HD44780 DDRAM model that
// answers set-address writes, data reads (auto-increment) and busy-flag reads.
// Honours LCD_READER_BUSY_POLL_EN the same way as the design.
module tb_lcd_ddram_reader;

`ifdef LCD_READER_BUSY_POLL_EN
  localparam int LAT       = 2302;  // 1 + 2*(54 + 4*54) + 32*55 + 1
  localparam int EXP_POLLS = 8;     // 4 busy reads on each line
  localparam int MID       = 400;
`else
  localparam int LAT       = 6870;  // 1 + 2*(54 + 2500) + 32*55 + 1
  localparam int EXP_POLLS = 0;
  localparam int MID       = 3000;
`endif
  localparam int BF_POLLS = 3;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic       gnt_tie = 1'b1;
  logic       gnt_force = 1'b0;
  logic       busy, done, bus_req, bus_gnt;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_data_oe, we;
  logic [7:0] lcd_data_out, lcd_data_in, dout;
  logic [4:0] waddr;

  // LCD model state
  logic [7:0] ddram [0:127];
  logic [6:0] addr = 7'd0;
  logic       en_prev = 1'b0;
  logic       m_rs = 1'b0, m_rw = 1'b1;
  logic [7:0] m_dat = 8'h00;
  int         bf_left = 0;
  int         n80 = 0, nc0 = 0, bf_reads = 0;

  // Monitors
  logic [7:0] ram [0:31];
  int         cyc = 0;
  int         we_count = 0, order_err = 0, done_count = 0, done_cyc = 0, viol = 0;
  int         we_base = 0, done_base = 0, n80_base = 0, nc0_base = 0, bf_base = 0;
  int         t_start = 0;
  int         n_chk = 0, n_err = 0;

  assign bus_gnt     = gnt_tie ? bus_req : gnt_force;
  assign lcd_data_in = (lcd_en && lcd_rw) ? (lcd_rs ? ddram[addr] : {bf_left != 0, addr}) : 8'h00;

  lcd_ddram_reader dut (
    .CLOCK_50     (CLOCK_50),
    .RST_N        (RST_N),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .lcd_data_in  (lcd_data_in),
    .waddr        (waddr),
    .dout         (dout),
    .we           (we)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // LCD model: latch the bus while en is high, act on the falling edge of en.
  always @(posedge CLOCK_50) begin
    en_prev <= lcd_en;
    if (lcd_en) begin
      m_rs  <= lcd_rs;
      m_rw  <= lcd_rw;
      m_dat <= lcd_data_out;
    end
    if (en_prev && !lcd_en) begin
      if (!m_rw) begin
        if (!m_rs && m_dat[7]) begin
          addr    <= m_dat[6:0];
          bf_left <= BF_POLLS;
        end
        if (!m_rs && m_dat == 8'h80) n80 <= n80 + 1;
        if (!m_rs && m_dat == 8'hC0) nc0 <= nc0 + 1;
      end else if (m_rs) begin
        addr <= addr + 7'd1;
      end else begin
        bf_reads <= bf_reads + 1;
        if (bf_left != 0) bf_left <= bf_left - 1;
      end
    end
  end

  // RAM-side and protocol monitors, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (we) begin
      if (waddr !== 5'(we_count - we_base)) order_err <= order_err + 1;
      ram[waddr] <= dout;
      we_count   <= we_count + 1;
    end
    if (done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
    if (lcd_data_oe && lcd_rw) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic snap();
    we_base   = we_count;
    done_base = done_count;
    n80_base  = n80;
    nc0_base  = nc0;
    bf_base   = bf_reads;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50);
    start   = 1'b1;
    t_start = cyc;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_count == done_base && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    tick(2);
    chk("done_seen", done_count - done_base, 1);
  endtask

  initial begin
    string l1, l2;
    int bad, t0, g_cyc, n;
    logic en_seen;
    l1 = "HELLO WORLD     ";
    l2 = "DE2-115 LCD DEMO";
    for (int i = 0; i < 128; i++) ddram[i] = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      ddram[i]      = l1[i];
      ddram[64 + i] = l2[i];
    end

    // Reset and idle
    RST_N = 1'b0;
    tick(5);
    RST_N = 1'b1;
    tick(100);
    chk("idle_rw", lcd_rw, 1);
    chk("idle_en", lcd_en, 0);
    chk("idle_oe", lcd_data_oe, 0);
    chk("idle_req", bus_req, 0);
    chk("idle_busy", busy, 0);
    chk("idle_we", we, 0);
    chk("idle_done", done, 0);

    // Full readback with immediate grant
    snap();
    pulse_start();
    chk("run_busy", busy, 1);
    wait_done(LAT + 200);
    chk("run_lat", done_cyc - t_start, LAT);
    chk("run_we_n", we_count - we_base, 32);
    chk("run_order", order_err, 0);
    chk("run_ram0", ram[0], 8'h48);
    chk("run_ram16", ram[16], 8'h44);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (ram[i] !== l1[i]) bad++;
      if (ram[16 + i] !== l2[i]) bad++;
    end
    chk("run_ram_all", bad, 0);
    chk("run_cmd80", n80 - n80_base, 1);
    chk("run_cmdc0", nc0 - nc0_base, 1);
    chk("run_bfreads", bf_reads - bf_base, EXP_POLLS);
    chk("run_end_busy", busy, 0);
    chk("run_end_req", bus_req, 0);

    // Grant withheld for 1000 cycles
    snap();
    gnt_tie   = 1'b0;
    gnt_force = 1'b0;
    pulse_start();
    en_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLOCK_50);
      if (lcd_en) en_seen = 1'b1;
    end
    chk("gnt_req", bus_req, 1);
    chk("gnt_en_none", en_seen, 0);
    chk("gnt_busy", busy, 1);
    chk("gnt_rw_wait", lcd_rw, 1);
    gnt_force = 1'b1;
    g_cyc = cyc;
    tick(1);
    chk("gnt_oe_start", lcd_data_oe, 1);
    chk("gnt_rw_start", lcd_rw, 0);
    chk("gnt_cmd", lcd_data_out, 8'h80);
    wait_done(LAT + 200);
    chk("gnt_lat", done_cyc - g_cyc, LAT - 1);
    chk("gnt_we_n", we_count - we_base, 32);
    gnt_force = 1'b0;
    gnt_tie   = 1'b1;

    // Second start during readback is ignored
    snap();
    pulse_start();
    t0 = t_start;
    tick(MID);
    chk("dbl_busy", busy, 1);
    pulse_start();
    wait_done(LAT + 200);
    chk("dbl_lat", done_cyc - t0, LAT);
    tick(100);
    chk("dbl_we_n", we_count - we_base, 32);
    chk("dbl_done_n", done_count - done_base, 1);
    chk("dbl_busy_end", busy, 0);
    chk("dbl_order", order_err, 0);

    // Reset during the read of character 7
    snap();
    pulse_start();
    n = 0;
    while ((we_count - we_base) < 7 && n < LAT) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("rst_pre_we", we_count - we_base, 7);
    tick(18);
    chk("rst_pre_en", lcd_en, 1);
    chk("rst_pre_rs", lcd_rs, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_en", lcd_en, 0);
    chk("rst_oe", lcd_data_oe, 0);
    chk("rst_rw", lcd_rw, 1);
    chk("rst_req", bus_req, 0);
    tick(5);
    RST_N = 1'b1;
    tick(200);
    chk("rst_we_n", we_count - we_base, 7);
    chk("rst_busy", busy, 0);
    chk("rst_done_n", done_count - done_base, 0);
    chk("oe_rw_excl", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
